// File: rtl/lda_line_engine.sv
// Bresenham line engine: latches a line request, normalises it to a shallow,
// left-to-right line, then emits one registered pixel per clock until the end point.
module lda_line_engine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [8:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [8:0] i_x1,
    input  logic [7:0] i_y1,
    input  logic [2:0] i_color,
    output logic       o_plot,
    output logic [8:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_color,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_INIT,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Endpoint registers are reused: raw request in SETUP, normalised line in INIT.
    logic [8:0]        ax0;
    logic [8:0]        ay0;
    logic [8:0]        ax1;
    logic [8:0]        ay1;
    logic [2:0]        color;
    logic              steep;
    logic [8:0]        x;
    logic [8:0]        y;
    logic [8:0]        xend;
    logic [8:0]        dx;
    logic [8:0]        dy;
    logic signed [10:0] err;
    logic              ystep_neg;

    logic [8:0]        adx;
    logic [8:0]        ady;
    logic              is_steep;
    logic [8:0]        sx0;
    logic [8:0]        sy0;
    logic [8:0]        sx1;
    logic [8:0]        sy1;
    logic [8:0]        init_dx;
    logic [8:0]        init_dy;
    logic [8:0]        init_half;
    logic signed [10:0] init_err;
    logic signed [10:0] err_sum;
    logic              step_y;
    logic [8:0]        x_adv;
    logic [8:0]        y_adv;
    logic signed [10:0] err_adv;

    always_comb begin
        adx       = (ax1 >= ax0) ? (ax1 - ax0) : (ax0 - ax1);
        ady       = (ay1 >= ay0) ? (ay1 - ay0) : (ay0 - ay1);
        is_steep  = ady > adx;
        sx0       = is_steep ? ay0 : ax0;
        sy0       = is_steep ? ax0 : ay0;
        sx1       = is_steep ? ay1 : ax1;
        sy1       = is_steep ? ax1 : ay1;

        init_dx   = ax1 - ax0;
        init_dy   = (ay1 >= ay0) ? (ay1 - ay0) : (ay0 - ay1);
        init_half = init_dx >> 1;
        init_err  = 11'sd0 - $signed({2'b00, init_half});

        // 11-bit signed error covers the worst case of dx, dy = 511 without wrapping.
        err_sum   = err + $signed({2'b00, dy});
        step_y    = err_sum > 11'sd0;
        x_adv     = x + 9'd1;
        y_adv     = y;
        if (step_y) begin
            y_adv = ystep_neg ? (y - 9'd1) : (y + 9'd1);
        end
        err_adv   = step_y ? (err_sum - $signed({2'b00, dx})) : err_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (i_start) state_next = S_SETUP;
            S_SETUP: state_next = S_INIT;
            S_INIT:  state_next = S_DRAW;
            S_DRAW:  if (x == xend) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax0       <= '0;
            ay0       <= '0;
            ax1       <= '0;
            ay1       <= '0;
            color     <= '0;
            steep     <= 1'b0;
            x         <= '0;
            y         <= '0;
            xend      <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            ystep_neg <= 1'b0;
            o_plot    <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
            o_color   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        ax0    <= i_x0;
                        ay0    <= {1'b0, i_y0};
                        ax1    <= i_x1;
                        ay1    <= {1'b0, i_y1};
                        color  <= i_color;
                        o_busy <= 1'b1;
                    end
                end
                S_SETUP: begin
                    steep <= is_steep;
                    if (sx0 > sx1) begin
                        ax0 <= sx1;
                        ay0 <= sy1;
                        ax1 <= sx0;
                        ay1 <= sy0;
                    end else begin
                        ax0 <= sx0;
                        ay0 <= sy0;
                        ax1 <= sx1;
                        ay1 <= sy1;
                    end
                end
                S_INIT: begin
                    dx        <= init_dx;
                    dy        <= init_dy;
                    err       <= init_err;
                    ystep_neg <= !(ay0 < ay1);
                    x         <= ax0;
                    y         <= ay0;
                    xend      <= ax1;
                    o_plot    <= 1'b1;
                    o_x       <= steep ? ay0 : ax0;
                    o_y       <= steep ? ax0[7:0] : ay0[7:0];
                    o_color   <= color;
                end
                S_DRAW: begin
                    // Output registers always hold the pixel for the current x, so the
                    // next pixel is formed from the advanced coordinates.
                    if (x == xend) begin
                        o_plot  <= 1'b0;
                        o_done  <= 1'b1;
                        o_x     <= '0;
                        o_y     <= '0;
                        o_color <= '0;
                    end else begin
                        x   <= x_adv;
                        y   <= y_adv;
                        err <= err_adv;
                        o_x <= steep ? y_adv : x_adv;
                        o_y <= steep ? x_adv[7:0] : y_adv[7:0];
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    o_plot <= 1'b0;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lda_line_engine.sv
// Directed bench for lda_line_engine: drives line requests, records every cycle's
// outputs relative to the start edge and compares against hand-derived pixel lists.
module tb_lda_line_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [8:0] i_x0;
    logic [7:0] i_y0;
    logic [8:0] i_x1;
    logic [7:0] i_y1;
    logic [2:0] i_color;
    logic       o_plot;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_color;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int failures = 0;

    int plot_x[$];
    int plot_y[$];
    int plot_c[$];
    int first_plot;
    int last_plot;
    int done_cycle;
    int done_count;
    int busy_first;
    int busy_last;
    int busy_after_done;
    int timed_out;

    always #5 clk = ~clk;

    lda_line_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_x0    (i_x0),
        .i_y0    (i_y0),
        .i_x1    (i_x1),
        .i_y1    (i_y1),
        .i_color (i_color),
        .o_plot  (o_plot),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_color (o_color),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Cycle k is sampled 1 ns after the k-th rising edge following the start edge.
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input int col, input int abort_after, input bit pulse_start);
        int cycle;
        plot_x.delete();
        plot_y.delete();
        plot_c.delete();
        first_plot = -1;
        last_plot = -1;
        done_cycle = -1;
        done_count = 0;
        busy_first = -1;
        busy_last = -1;
        busy_after_done = 0;
        timed_out = 0;
        @(negedge clk);
        i_x0 = 9'(x0);
        i_y0 = 8'(y0);
        i_x1 = 9'(x1);
        i_y1 = 8'(y1);
        i_color = 3'(col);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_x0 = 9'd301;
        i_y0 = 8'd77;
        i_x1 = 9'd5;
        i_y1 = 8'd200;
        i_color = 3'd7;
        cycle = 1;
        forever begin
            if (o_plot) begin
                plot_x.push_back(int'(o_x));
                plot_y.push_back(int'(o_y));
                plot_c.push_back(int'(o_color));
                if (first_plot < 0) first_plot = cycle;
                last_plot = cycle;
            end
            if (o_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cycle;
            end
            if (o_busy) begin
                if (busy_first < 0) busy_first = cycle;
                busy_last = cycle;
                if (done_cycle >= 0 && cycle > done_cycle) busy_after_done++;
            end
            i_start = pulse_start && (cycle == 40 || cycle == 41 || cycle == 200 || cycle == done_cycle);
            if (abort_after > 0 && plot_x.size() == abort_after) break;
            if (done_cycle >= 0 && cycle >= done_cycle + 2) break;
            if (cycle >= 1000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk);
            #1;
            cycle++;
        end
        i_start = 1'b0;
    endtask

    task automatic checkPlots(input string tag, input int n, input int ex[8], input int ey[8]);
        checkOutput({tag, "_count"}, plot_x.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_x%0d", tag, i), (i < plot_x.size()) ? plot_x[i] : -1, ex[i]);
            checkOutput($sformatf("%s_y%0d", tag, i), (i < plot_y.size()) ? plot_y[i] : -1, ey[i]);
        end
        checkOutput({tag, "_contiguous"}, last_plot - first_plot + 1, n);
        checkOutput({tag, "_first_plot_cycle"}, first_plot, 3);
        checkOutput({tag, "_done_cycle"}, done_cycle, n + 3);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_timeout"}, timed_out, 0);
    endtask

    initial begin
        int ex[8];
        int ey[8];
        int bad_y;
        int bad_x;
        int yexp;
        int diff;
        int done_in_reset;

        rst_n = 1'b0;
        i_start = 1'b0;
        i_x0 = '0;
        i_y0 = '0;
        i_x1 = '0;
        i_y1 = '0;
        i_color = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_plot", o_plot, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_xy", {o_x, o_y}, 0);
        checkOutput("reset_color", o_color, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single point
        applyStimulus(7, 9, 7, 9, 5, 0, 1'b0);
        ex = '{7, 0, 0, 0, 0, 0, 0, 0};
        ey = '{9, 0, 0, 0, 0, 0, 0, 0};
        checkPlots("point", 1, ex, ey);
        checkOutput("point_color", (plot_c.size() > 0) ? plot_c[0] : -1, 5);
        checkOutput("point_busy_first", busy_first, 1);
        checkOutput("point_busy_last", busy_last, 4);

        // Horizontal, endpoints reversed
        applyStimulus(13, 5, 10, 5, 2, 0, 1'b0);
        ex = '{10, 11, 12, 13, 0, 0, 0, 0};
        ey = '{5, 5, 5, 5, 0, 0, 0, 0};
        checkPlots("horiz", 4, ex, ey);
        checkOutput("horiz_busy_last", busy_last, 7);

        // Steep line
        applyStimulus(0, 0, 2, 5, 3, 0, 1'b0);
        ex = '{0, 0, 1, 1, 2, 2, 0, 0};
        ey = '{0, 1, 2, 3, 4, 5, 0, 0};
        checkPlots("steep", 6, ex, ey);

        // Diagonal with decreasing y
        applyStimulus(0, 4, 4, 0, 1, 0, 1'b0);
        ex = '{0, 1, 2, 3, 4, 0, 0, 0};
        ey = '{4, 3, 2, 1, 0, 0, 0, 0};
        checkPlots("diag", 5, ex, ey);

        // Full width with start pulses while busy and during DONE
        applyStimulus(0, 0, 335, 209, 6, 0, 1'b1);
        checkOutput("full_count", plot_x.size(), 336);
        checkOutput("full_done_cycle", done_cycle, 339);
        checkOutput("full_done_count", done_count, 1);
        checkOutput("full_contiguous", last_plot - first_plot + 1, 336);
        checkOutput("full_last_x", (plot_x.size() > 0) ? plot_x[plot_x.size() - 1] : -1, 335);
        checkOutput("full_last_y", (plot_y.size() > 0) ? plot_y[plot_y.size() - 1] : -1, 209);
        bad_x = 0;
        bad_y = 0;
        for (int i = 0; i < plot_x.size(); i++) begin
            if (plot_x[i] != i) bad_x++;
            yexp = (plot_x[i] * 418 + 335) / 670;
            diff = plot_y[i] - yexp;
            if (diff > 1 || diff < -1) bad_y++;
        end
        checkOutput("full_x_ascending", bad_x, 0);
        checkOutput("full_y_tolerance", bad_y, 0);
        checkOutput("full_no_restart", busy_after_done, 0);
        checkOutput("full_timeout", timed_out, 0);

        // Reset in the middle of a line
        applyStimulus(0, 0, 20, 3, 2, 3, 1'b0);
        checkOutput("abort_plots_seen", plot_x.size(), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_plot", o_plot, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_xy", {o_x, o_y}, 0);
        done_in_reset = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_done) done_in_reset++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (o_done || o_busy) done_in_reset++;
        end
        checkOutput("abort_no_done", done_in_reset, 0);

        applyStimulus(1, 1, 2, 1, 6, 0, 1'b0);
        ex = '{1, 2, 0, 0, 0, 0, 0, 0};
        ey = '{1, 1, 0, 0, 0, 0, 0, 0};
        checkPlots("after_reset", 2, ex, ey);
        checkOutput("after_reset_color", (plot_c.size() > 1) ? plot_c[1] : -1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lda_line_engine.md
# lda_line_engine

Bresenham line-drawing engine that consumes the start/coordinate/colour outputs of the Avalon slave controller and emits one pixel write per clock to the VGA frame-buffer adapter. When a line completes, it returns a one-cycle done pulse to the controller, which releases its waitrequest.

## Interface
- No parameters. Coordinate widths are fixed at 9-bit X and 8-bit Y. Colour is 3-bit.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level or pulse; sampled only in IDLE
- i_x0  in  9  start X
- i_y0  in  8  start Y
- i_x1  in  9  end X
- i_y1  in  8  end Y
- i_color  in  3  pixel colour
- o_plot  out  1  pixel write enable, one pixel per high cycle
- o_x  out  9  pixel X, valid while o_plot
- o_y  out  8  pixel Y, valid while o_plot
- o_color  out  3  pixel colour, valid while o_plot
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at line completion

## Operation
- States and transitions:
  - IDLE → SETUP when i_start=1.
  - SETUP → INIT.
  - INIT → DRAW.
  - DRAW → DRAW while x≠xend; DRAW → DONE after the pixel at x=xend.
  - DONE → IDLE unconditionally.
- IDLE, on i_start: latch i_x0, i_y0, i_x1, i_y1 and i_color. Input changes after this edge have no effect on the current line.
- SETUP:
  - steep = |y1−y0| > |x1−x0|, computed with 9-bit unsigned magnitudes.
  - If steep, swap x↔y on both endpoints. Internal coordinates are 9 bits.
  - If the resulting x0 > x1, swap the two endpoints.
- INIT:
  - dx = x1−x0 and dy = |y1−y0|.
  - err = −(dx>>1), a signed 11-bit value; dx>>1 truncates.
  - ystep = +1 if y0<y1, else −1.
  - x = x0, y = y0, xend = x1.
- DRAW, each cycle:
  - Drive o_plot=1. Drive (o_x,o_y) = steep ? (y,x) : (x,y), truncating Y to 8 bits.
  - Update err' = err+dy. If err' > 0 (signed), then y += ystep and err = err'−dx; else err = err'.
  - Advance x += 1.
- DONE: o_done=1 for exactly one cycle, o_plot=0.
- Pixels are always emitted in ascending order of the major-axis coordinate, regardless of the endpoint order given.
- Pixel count is N = max(|x1−x0|, |y1−y0|) + 1. A single-point line (both endpoints equal) yields N=1.
- i_start while busy, including during DONE: ignored. The engine never queues a second line.
- i_start held high across DONE→IDLE: starts a new line on the IDLE cycle. This is legal; the controller drops start on done.
- Arithmetic: err must not overflow for dx, dy ≤ 511.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - o_plot=0, o_done=0, o_busy=0.
  - o_x=0, o_y=0, o_color=0.
  - All internal registers cleared.
- Reset asserted mid-line: outputs drop to reset values immediately, with no o_done. The engine is idle on the first edge after release.
- All outputs are registered. There are no combinational input→output paths.
- Edge E0 samples i_start. Then:
  - SETUP during cycle 1.
  - INIT during cycle 2.
  - o_plot high for cycles 3 … N+2, back-to-back with no gaps.
  - o_done high during cycle N+3.
  - IDLE from cycle N+4.
- o_busy is high for cycles 1 … N+3.
- Start-to-done latency is N+3 cycles.
- There is no backpressure. The downstream consumer must accept one pixel per cycle.

## Test plan
- Single point (7,9)→(7,9), colour 5 → exactly one plot (7,9,5) in cycle 3; o_done in cycle 4; o_busy high for cycles 1–4.
- Horizontal reversed (13,5)→(10,5) → plots (10,5),(11,5),(12,5),(13,5) on consecutive cycles; o_done one cycle after the last plot.
- Steep (0,0)→(2,5) → plots (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); o_done in cycle 9.
- Diagonal up-right (0,4)→(4,0) → plots (0,4),(1,3),(2,2),(3,1),(4,0); ystep −1 exercised.
- Full width (0,0)→(335,209) → 336 plots. Every plot must satisfy |y − round(x·209/335)| ≤ 1. Last plot (335,209). i_start pulses mid-line are ignored, and the plot count is unchanged.
- Reset mid-line: assert rst_n=0 after the third plot → o_plot, o_busy, o_x, o_y drop to 0 asynchronously and no o_done follows. A new line (1,1)→(2,1) after release draws exactly 2 plots.
